// File: rtl/wb_collector.sv
// Writeback collector: captures execute-stage result pulses into one in-order FIFO
// and drains up to WB_PORTS entries per cycle onto the scoreboard write ports.
package wb_collector_pkg;
    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;
endpackage

module wb_collector
    import wb_collector_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 5,
    parameter int unsigned WB_PORTS      = 2,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    flush_i,
    input  logic [NUM_SRC-1:0]                      src_valid_i,
    input  logic [NUM_SRC-1:0][TRANS_ID_BITS-1:0]   src_trans_id_i,
    input  logic [NUM_SRC-1:0][XLEN-1:0]            src_result_i,
    input  exception_t [NUM_SRC-1:0]                src_ex_i,
    output logic [WB_PORTS-1:0]                     wb_valid_o,
    output logic [WB_PORTS-1:0][TRANS_ID_BITS-1:0]  wb_trans_id_o,
    output logic [WB_PORTS-1:0][XLEN-1:0]           wb_result_o,
    output exception_t [WB_PORTS-1:0]               wb_ex_o,
    output logic                                    almost_full_o,
    output logic [$clog2(DEPTH):0]                  count_o,
    output logic                                    overflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] id;
        logic [XLEN-1:0]          result;
        exception_t               ex;
    } entry_t;

    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;

    logic [CW-1:0]      pops;
    logic [CW-1:0]      capacity;
    logic [CW-1:0]      pushes;

    // Drain from the head, then append accepted sources in index order.
    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        wb_valid_o    = '0;
        wb_trans_id_o = '0;
        wb_result_o   = '0;
        wb_ex_o       = '0;
        pushes        = '0;
        pops          = (count_q > CW'(WB_PORTS)) ? CW'(WB_PORTS) : count_q;
        capacity      = CW'(DEPTH) - count_q + pops;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            for (int unsigned j = 0; j < WB_PORTS; j++) begin
                if (CW'(j) < pops) begin
                    wb_valid_o[j]    = 1'b1;
                    wb_trans_id_o[j] = mem_q[rd_ptr_q + PW'(j)].id;
                    wb_result_o[j]   = mem_q[rd_ptr_q + PW'(j)].result;
                    wb_ex_o[j]       = mem_q[rd_ptr_q + PW'(j)].ex;
                end
            end
            // Slots freed by this cycle's pops may be reused: reads above use mem_q.
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                if (src_valid_i[k]) begin
                    if (pushes < capacity) begin
                        mem_d[wr_ptr_q + PW'(pushes)] = '{id: src_trans_id_i[k],
                                                          result: src_result_i[k],
                                                          ex: src_ex_i[k]};
                        pushes = pushes + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            wr_ptr_d = wr_ptr_q + PW'(pushes);
            rd_ptr_d = rd_ptr_q + PW'(pops);
            count_d  = count_q - pops + pushes;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign almost_full_o = (CW'(DEPTH) - count_q) < CW'(2 * NUM_SRC);
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;

endmodule
